// File: rtl/telemetry_frame_sched.sv
// telemetry_frame_sched: periodic 6-byte telemetry framer feeding a byte-wide UART.
// Every PERIOD_CLOCKS cycles the latest temperature sample is snapshotted and
// streamed as SYNC, seq, flags, temp hi, temp lo, check over valid/ready.
// Build option: define TELEM_CRC8_EN to make the check byte a CRC-8 (poly 0x07)
// instead of the default XOR checksum.
module telemetry_frame_sched #(
  parameter int         PERIOD_CLOCKS = 12000000,
  parameter logic [7:0] SYNC_BYTE     = 8'hA5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic [15:0] temp_data,
  input  logic        temp_sign,
  input  logic        temp_valid,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        frame_active,
  output logic [7:0]  seq_num,
  output logic        overrun
);

  localparam int            CW      = $clog2(PERIOD_CLOCKS);
  localparam logic [CW-1:0] CNT_MAX = CW'(PERIOD_CLOCKS - 1);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_SEND = 1'b1;

  logic [CW-1:0] cnt_q, cnt_d;
  logic          tick;
  logic [15:0]   temp_q, temp_d;
  logic          sign_q, sign_d;
  logic          fresh_q, fresh_d;
  logic [0:0]    state_q, state_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    seq_q, seq_d;
  logic [7:0]    chk_q, chk_d;
  logic [15:0]   snap_temp_q, snap_temp_d;
  logic          snap_sign_q, snap_sign_d;
  logic          stale_q, stale_d;
  logic          ovr_q, ovr_d;
  logic [7:0]    byte_mux;
  logic          start;

`ifdef TELEM_CRC8_EN
  // One byte of CRC-8, poly 0x07, MSB first, no reflection.
  function automatic logic [7:0] chk_step(input logic [7:0] c, input logic [7:0] d);
    logic [7:0] r;
    r = c ^ d;
    for (int i = 0; i < 8; i++) r = r[7] ? ((r << 1) ^ 8'h07) : (r << 1);
    return r;
  endfunction
`else
  // Plain XOR checksum of the payload bytes.
  function automatic logic [7:0] chk_step(input logic [7:0] c, input logic [7:0] d);
    return c ^ d;
  endfunction
`endif

  // Period counter: free-runs while enabled, parked at zero otherwise.
  assign tick = en && (cnt_q == CNT_MAX);
  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (!en || tick) cnt_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign start = (state_q == ST_IDLE) && tick;

  // Latest sample plus a freshness flag consumed by each frame start.
  always_comb begin
    temp_d  = temp_valid ? temp_data : temp_q;
    sign_d  = temp_valid ? temp_sign : sign_q;
    fresh_d = start ? 1'b0 : (temp_valid | fresh_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      temp_q  <= '0;
      sign_q  <= 1'b0;
      fresh_q <= 1'b0;
    end else begin
      temp_q  <= temp_d;
      sign_q  <= sign_d;
      fresh_q <= fresh_d;
    end
  end

  // Outgoing byte selected by the frame index; zero while idle.
  always_comb begin
    byte_mux = 8'h00;
    if (state_q == ST_SEND) begin
      case (idx_q)
        3'd0:    byte_mux = SYNC_BYTE;
        3'd1:    byte_mux = seq_q;
        3'd2:    byte_mux = {snap_sign_q, stale_q, 6'b0};
        3'd3:    byte_mux = snap_temp_q[15:8];
        3'd4:    byte_mux = snap_temp_q[7:0];
        default: byte_mux = chk_q;
      endcase
    end
  end

  // Frame sequencer: snapshot on tick, advance on each accepted byte.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    seq_d       = seq_q;
    chk_d       = chk_q;
    snap_temp_d = snap_temp_q;
    snap_sign_d = snap_sign_q;
    stale_d     = stale_q;
    ovr_d       = ovr_q | (tick && (state_q == ST_SEND));
    case (state_q)
      ST_IDLE: begin
        if (tick) begin
          state_d = ST_SEND;
          idx_d   = 3'd0;
          seq_d   = seq_q + 8'd1;
          chk_d   = 8'h00;
          // A sample arriving on the tick cycle is the freshest available.
          if (temp_valid) begin
            snap_temp_d = temp_data;
            snap_sign_d = temp_sign;
            stale_d     = 1'b0;
          end else begin
            snap_temp_d = temp_q;
            snap_sign_d = sign_q;
            stale_d     = ~fresh_q;
          end
        end
      end
      default: begin
        if (tx_ready) begin
          if (idx_q == 3'd5) state_d = ST_IDLE;
          else               idx_d   = idx_q + 3'd1;
          if (idx_q >= 3'd1 && idx_q <= 3'd4) chk_d = chk_step(chk_q, byte_mux);
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      idx_q       <= 3'd0;
      seq_q       <= 8'hFF;
      chk_q       <= 8'h00;
      snap_temp_q <= '0;
      snap_sign_q <= 1'b0;
      stale_q     <= 1'b0;
      ovr_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      seq_q       <= seq_d;
      chk_q       <= chk_d;
      snap_temp_q <= snap_temp_d;
      snap_sign_q <= snap_sign_d;
      stale_q     <= stale_d;
      ovr_q       <= ovr_d;
    end
  end

  assign tx_data      = byte_mux;
  assign tx_valid     = (state_q == ST_SEND);
  assign frame_active = (state_q == ST_SEND);
  assign seq_num      = seq_q;
  assign overrun      = ovr_q;

endmodule

// File: tb/tb_telemetry_frame_sched.sv
// Directed bench for telemetry_frame_sched with PERIOD_CLOCKS=100.
// Frames are described in a vector table; reset/enable corners are hand sequences.
module tb_telemetry_frame_sched;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic [15:0] temp_data;
  logic        temp_sign;
  logic        temp_valid;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        frame_active;
  logic [7:0]  seq_num;
  logic        overrun;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  telemetry_frame_sched #(.PERIOD_CLOCKS(100), .SYNC_BYTE(8'hA5)) dut (
    .clk(clk), .rst_n(rst_n), .en(en),
    .temp_data(temp_data), .temp_sign(temp_sign), .temp_valid(temp_valid),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .frame_active(frame_active), .seq_num(seq_num), .overrun(overrun)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference CRC-8 (poly 0x07), computed bit-serially per input bit.
  function automatic logic [7:0] crc_model(input logic [7:0] b1, b2, b3, b4);
    logic [7:0]  c;
    logic [31:0] s;
    logic        fb;
    c = 8'h00;
    s = {b1, b2, b3, b4};
    for (int i = 31; i >= 0; i--) begin
      fb = c[7] ^ s[i];
      c  = {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
    end
    return c;
  endfunction

  // Collect one 6-byte frame. mode 0: ready always high; 1: ready 1,0,0,1 pattern;
  // 2: ready low for the first 150 valid cycles; 3: ready high, en dropped after 2 accepts.
  task automatic collect(input int mode, output logic [5:0][7:0] got, output int start_cyc);
    int n, w, k, viol, first_acc, span;
    logic pv, pa;
    logic [7:0] pd;
    n = 0; w = 0; k = 0; viol = 0; first_acc = 0; span = -1;
    pv = 1'b0; pa = 1'b0; pd = 8'h00; got = '0; start_cyc = -1;
    while (n < 6 && w < 1000) begin
      @(negedge clk);
      w++;
      case (mode)
        1:       tx_ready = (k % 4 == 0) || (k % 4 == 3);
        2:       tx_ready = (k >= 150);
        default: tx_ready = 1'b1;
      endcase
      if (tx_valid) begin
        if (start_cyc < 0) start_cyc = cyc;
        if (!frame_active) viol++;
        if (pv && !pa && tx_data !== pd) viol++;
        if (mode == 2 && k == 149) chk("overrun_during_stall", overrun, 1);
        pa = tx_ready;
        pd = tx_data;
        if (tx_ready) begin
          got[n] = tx_data;
          if (n == 0) first_acc = cyc;
          if (n == 5) span = cyc - first_acc;
          n++;
          if (mode == 3 && n == 2) en = 1'b0;
        end
        k++;
      end else begin
        pa = 1'b0;
      end
      pv = tx_valid;
    end
    chk("frame_accepts", n, 6);
    chk("stall_stability_violations", viol, 0);
    if (mode == 0 || mode == 3) chk("back_to_back_span", span, 5);
    @(negedge clk);
    tx_ready = 1'b1;
    chk("valid_low_after_frame", tx_valid, 0);
    chk("active_low_after_frame", frame_active, 0);
  endtask

  typedef struct {
    logic             pulse;
    logic [15:0]      t;
    logic             s;
    int               mode;
    logic [5:0][7:0]  exp;   // exp[0] is the first byte on the wire
    logic             exp_ovr;
  } vec_t;

  vec_t vecs[6];

  initial begin
    logic [5:0][7:0] got;
    logic [7:0]      e5;
    int              st, base, vcount, n, w;

    vecs[0] = '{1'b1, 16'h0190, 1'b0, 0, {8'h91, 8'h90, 8'h01, 8'h00, 8'h00, 8'hA5}, 1'b0};
    vecs[1] = '{1'b0, 16'h0000, 1'b0, 0, {8'hD0, 8'h90, 8'h01, 8'h40, 8'h01, 8'hA5}, 1'b0};
    vecs[2] = '{1'b1, 16'h0123, 1'b1, 1, {8'hA0, 8'h23, 8'h01, 8'h80, 8'h02, 8'hA5}, 1'b0};
    vecs[3] = '{1'b1, 16'hFFFF, 1'b0, 0, {8'h03, 8'hFF, 8'hFF, 8'h00, 8'h03, 8'hA5}, 1'b0};
    vecs[4] = '{1'b0, 16'h0000, 1'b0, 2, {8'h44, 8'hFF, 8'hFF, 8'h40, 8'h04, 8'hA5}, 1'b1};
    vecs[5] = '{1'b0, 16'h0000, 1'b0, 3, {8'h45, 8'hFF, 8'hFF, 8'h40, 8'h05, 8'hA5}, 1'b1};

    rst_n = 1'b0; en = 1'b0; temp_data = '0; temp_sign = 1'b0; temp_valid = 1'b0; tx_ready = 1'b1;
    #12;
    chk("reset_tx_data", tx_data, 8'h00);
    chk("reset_tx_valid", tx_valid, 0);
    chk("reset_frame_active", frame_active, 0);
    chk("reset_seq_num", seq_num, 8'hFF);
    chk("reset_overrun", overrun, 0);

    @(negedge clk);
    rst_n = 1'b1;
    en    = 1'b1;
    base  = cyc;

    for (int i = 0; i < 6; i++) begin
      if (vecs[i].pulse) begin
        @(negedge clk);
        temp_data = vecs[i].t; temp_sign = vecs[i].s; temp_valid = 1'b1;
        @(negedge clk);
        temp_valid = 1'b0;
      end
      collect(vecs[i].mode, got, st);
      if (i == 0) chk("first_frame_latency", st - base, 100);
`ifdef TELEM_CRC8_EN
      e5 = crc_model(vecs[i].exp[1], vecs[i].exp[2], vecs[i].exp[3], vecs[i].exp[4]);
`else
      e5 = vecs[i].exp[5];
`endif
      for (int b = 0; b < 5; b++) chk($sformatf("vec%0d_byte%0d", i, b), got[b], vecs[i].exp[b]);
      chk($sformatf("vec%0d_byte5_check", i), got[5], e5);
      chk($sformatf("vec%0d_seq_num", i), seq_num, vecs[i].exp[1]);
      chk($sformatf("vec%0d_overrun", i), overrun, vecs[i].exp_ovr);
    end

    // en stayed low after the last table frame: no further frames may start.
    vcount = 0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (tx_valid) vcount++;
    end
    chk("disabled_no_valid", vcount, 0);

    // Re-enable: a counter parked at 0 gives the full period before the next frame.
    en   = 1'b1;
    base = cyc;
    collect(0, got, st);
    chk("reenable_latency", st - base, 100);
    chk("reenable_seq_byte", got[1], 8'h06);
    chk("reenable_flags_byte", got[2], 8'h40);

    // Reset during a frame, after byte 2 has been accepted.
    n = 0; w = 0; tx_ready = 1'b1;
    while (n < 3 && w < 300) begin
      @(negedge clk);
      w++;
      if (tx_valid) n++;
    end
    chk("pre_reset_bytes_presented", n, 3);
    @(negedge clk);
    chk("pre_reset_mid_frame", tx_valid, 1);
    rst_n = 1'b0;
    #1;
    chk("midreset_tx_valid", tx_valid, 0);
    chk("midreset_frame_active", frame_active, 0);
    chk("midreset_tx_data", tx_data, 8'h00);
    chk("midreset_seq_num", seq_num, 8'hFF);
    chk("midreset_overrun", overrun, 0);
    @(negedge clk);
    rst_n = 1'b1;
    base  = cyc;
    collect(0, got, st);
    chk("post_reset_latency", st - base, 100);
    chk("post_reset_sync", got[0], 8'hA5);
    chk("post_reset_seq", got[1], 8'h00);
    chk("post_reset_flags", got[2], 8'h40);
    chk("post_reset_temp_hi", got[3], 8'h00);
    chk("post_reset_temp_lo", got[4], 8'h00);
`ifdef TELEM_CRC8_EN
    e5 = crc_model(8'h00, 8'h40, 8'h00, 8'h00);
`else
    e5 = 8'h40;
`endif
    chk("post_reset_check", got[5], e5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
